// File: rtl/mbist_sched_pkg.sv
// Purpose : shared types and constants for the MBIST sweep scheduler.
// Latency : n/a (types, constants and one pure helper function).
// Backpr. : n/a.
// Contents: FSM state enum, frame geometry, settle length, cfg bit ordering,
//           build_frame() which lays out one complete serial setup frame.
package mbist_sched_pkg;

    localparam int CFG_W      = 7;
    localparam int FRAME_LEN  = 8;
    localparam int SETTLE_CYC = 8;
    localparam int SETTLE_W   = $clog2(SETTLE_CYC + 1);

    // cfg bit carried by frame slots 1..7 (slot 0 is the start bit).
    // Three bits per slot, slot 1 in the LSBs: cfg[0], cfg[6], cfg[1] .. cfg[5].
    localparam logic [3*CFG_W-1:0] CFG_ORDER = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd6, 3'd0};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_WAIT,
        ST_NEXT,
        ST_FIN
    } state_e;

    // Bit 0 goes on the wire first.
    function automatic logic [FRAME_LEN-1:0] build_frame(input logic [CFG_W-1:0] cfg);
        logic [FRAME_LEN-1:0] f;
        f    = '0;
        f[0] = 1'b1;
        for (int s = 0; s < CFG_W; s++) begin
            f[s+1] = cfg[CFG_ORDER[3*s +: 3]];
        end
        return f;
    endfunction

endpackage

// File: rtl/mbist_serial_tx.sv
// Purpose : serialises one setup frame (start bit + reordered cfg) onto a single line.
// Latency : load at cycle 0 -> start bit on ser_o at cycle 1, last bit at cycle FRAME_LEN.
// Backpr. : none; clr_i aborts the frame and drops the line on the next cycle.
// Ports   : clk_i/rst_i clock and async active-high reset; load_i starts a frame
//           built from cfg_i; ser_o is the registered serial bit; frame_done_o is
//           high during the cycle the last frame bit is on the line.
module mbist_serial_tx
    import mbist_sched_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             clr_i,
    input  logic [CFG_W-1:0] cfg_i,
    output logic             ser_o,
    output logic             frame_done_o
);

    localparam int CNT_W = $clog2(FRAME_LEN);

    logic [FRAME_LEN-1:0] frame_w;
    logic [FRAME_LEN-1:0] sh_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 act_q;
    logic                 ser_q;

    assign frame_w = build_frame(cfg_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sh_q  <= '0;
            cnt_q <= '0;
            act_q <= 1'b0;
            ser_q <= 1'b0;
        end else if (clr_i) begin
            sh_q  <= '0;
            cnt_q <= '0;
            act_q <= 1'b0;
            ser_q <= 1'b0;
        end else if (load_i) begin
            // Start bit goes out immediately; the rest waits in the shifter.
            ser_q <= frame_w[0];
            sh_q  <= frame_w >> 1;
            cnt_q <= CNT_W'(FRAME_LEN - 1);
            act_q <= 1'b1;
        end else if (act_q) begin
            if (cnt_q == '0) begin
                ser_q <= 1'b0;
                act_q <= 1'b0;
            end else begin
                ser_q <= sh_q[0];
                sh_q  <= sh_q >> 1;
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign ser_o        = ser_q;
    assign frame_done_o = act_q && (cnt_q == '0);

endmodule

// File: rtl/mbist_sched.sv
// Purpose : sequences a BIST sweep over the masked stubs: setup frame, settle, collect done/fail.
// Latency : start accepted at cycle 0 -> mbist_enable[idx] high at cycle 1; sweep_done one
//           cycle after FIN. Backpr.: none; start while busy is dropped, abort ends the sweep.
// Ports   : rclk/rst (async active-high); start/abort/cfg/stub_mask control; stub_done/
//           stub_fail per-stub status in; mbist_enable per-stub serial line out; busy,
//           sweep_done, fail_vec, tmo_vec status out.
// Option  : MBIST_SCHED_TIMEOUT_EN adds a TMO_W-bit done watchdog; without it WAIT waits
//           indefinitely and tmo_vec is tied low.
module mbist_sched
    import mbist_sched_pkg::*;
#(
    parameter int NUM_STUBS = 4,
    parameter int TMO_W     = 20
) (
    input  logic                 rclk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CFG_W-1:0]     cfg,
    input  logic [NUM_STUBS-1:0] stub_mask,
    input  logic [NUM_STUBS-1:0] stub_done,
    input  logic [NUM_STUBS-1:0] stub_fail,
    output logic [NUM_STUBS-1:0] mbist_enable,
    output logic                 busy,
    output logic                 sweep_done,
    output logic [NUM_STUBS-1:0] fail_vec,
    output logic [NUM_STUBS-1:0] tmo_vec
);

    localparam int IDX_W = (NUM_STUBS > 1) ? $clog2(NUM_STUBS) : 1;

    if ((NUM_STUBS < 1) || (NUM_STUBS > 16) || (TMO_W < 1)) begin : g_bad_param
        $error("mbist_sched: NUM_STUBS must be 1..16 and TMO_W at least 1");
    end

    state_e               state_q;
    logic [IDX_W-1:0]     idx_q;
    logic [CFG_W-1:0]     cfg_q;
    logic [NUM_STUBS-1:0] mask_q;
    logic [NUM_STUBS-1:0] fail_q;
    logic [SETTLE_W-1:0]  settle_q;
    logic                 sweep_done_q;

    logic [IDX_W-1:0]     first_idx_d;
    logic [IDX_W-1:0]     next_idx_d;
    logic                 next_vld_d;
    logic                 settled;
    logic                 sel_done;
    logic                 sel_fail;

    logic                 tx_load;
    logic                 tx_clr;
    logic [CFG_W-1:0]     tx_cfg;
    logic                 tx_ser;
    logic                 tx_frame_done;

`ifdef MBIST_SCHED_TIMEOUT_EN
    logic [TMO_W-1:0]     tmo_cnt_q;
    logic [NUM_STUBS-1:0] tmo_q;
    assign tmo_vec = tmo_q;
`else
    assign tmo_vec = '0;
`endif

    // Lowest masked stub of the live mask (sweep entry) and the next masked
    // stub strictly above idx in the captured mask (no wrap-around).
    always_comb begin
        first_idx_d = '0;
        next_idx_d  = '0;
        next_vld_d  = 1'b0;
        for (int i = NUM_STUBS - 1; i >= 0; i--) begin
            if (stub_mask[i]) begin
                first_idx_d = IDX_W'(i);
            end
            if (mask_q[i] && (i > int'(idx_q))) begin
                next_idx_d = IDX_W'(i);
                next_vld_d = 1'b1;
            end
        end
    end

    // Only the selected stub is ever looked at; the rest of the bus is don't-care.
    assign sel_done = stub_done[idx_q];
    assign sel_fail = stub_fail[idx_q];
    assign settled  = (settle_q == SETTLE_W'(SETTLE_CYC));

    // The frame is loaded on the same edge that enters SHIFT so the start bit
    // lands one cycle after start. In IDLE cfg_q is not captured yet, so the
    // live cfg feeds the shifter directly.
    assign tx_load = ((state_q == ST_IDLE) && start && (|stub_mask)) ||
                     ((state_q == ST_NEXT) && !abort && next_vld_d);
    assign tx_clr  = abort && (state_q != ST_IDLE);
    assign tx_cfg  = (state_q == ST_IDLE) ? cfg : cfg_q;

    mbist_serial_tx u_tx (
        .clk_i        (rclk),
        .rst_i        (rst),
        .load_i       (tx_load),
        .clr_i        (tx_clr),
        .cfg_i        (tx_cfg),
        .ser_o        (tx_ser),
        .frame_done_o (tx_frame_done)
    );

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cfg_q        <= '0;
            mask_q       <= '0;
            fail_q       <= '0;
            settle_q     <= '0;
            sweep_done_q <= 1'b0;
`ifdef MBIST_SCHED_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            tmo_q        <= '0;
`endif
        end else begin
            sweep_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // abort is meaningless here, so start always wins.
                    if (start) begin
                        cfg_q  <= cfg;
                        mask_q <= stub_mask;
                        fail_q <= '0;
`ifdef MBIST_SCHED_TIMEOUT_EN
                        tmo_q  <= '0;
`endif
                        idx_q  <= first_idx_d;
                        state_q <= (|stub_mask) ? ST_SHIFT : ST_FIN;
                    end
                end
                ST_SHIFT: begin
                    if (abort) begin
                        state_q <= ST_FIN;
                    end else if (tx_frame_done) begin
                        settle_q <= '0;
`ifdef MBIST_SCHED_TIMEOUT_EN
                        tmo_cnt_q <= '0;
`endif
                        state_q  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // abort beats a simultaneous done: nothing is recorded.
                    if (abort) begin
                        state_q <= ST_FIN;
                    end else if (settled && sel_done) begin
                        fail_q[idx_q] <= sel_fail;
                        state_q       <= ST_NEXT;
`ifdef MBIST_SCHED_TIMEOUT_EN
                    end else if (&tmo_cnt_q) begin
                        tmo_q[idx_q]  <= 1'b1;
                        fail_q[idx_q] <= 1'b1;
                        state_q       <= ST_NEXT;
`endif
                    end else begin
                        if (!settled) begin
                            settle_q <= settle_q + 1'b1;
                        end
`ifdef MBIST_SCHED_TIMEOUT_EN
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
`endif
                    end
                end
                ST_NEXT: begin
                    if (abort) begin
                        state_q <= ST_FIN;
                    end else if (next_vld_d) begin
                        idx_q   <= next_idx_d;
                        state_q <= ST_SHIFT;
                    end else begin
                        state_q <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    sweep_done_q <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Demux the single serial line onto the selected stub; idx only moves
    // while the line is low, so no stray pulse reaches another stub.
    always_comb begin
        mbist_enable = '0;
        for (int i = 0; i < NUM_STUBS; i++) begin
            mbist_enable[i] = tx_ser && (idx_q == IDX_W'(i));
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign sweep_done = sweep_done_q;
    assign fail_vec   = fail_q;

endmodule
